// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner ids and
// the wait-counter width.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    // Arbiter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Requester identity
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Combinational two-way grant between instruction fetch and data requesters.
// Ports:
//   i_req, d_req   request levels
//   last_grant     owner of the most recently completed transaction
//   grant_valid    at least one request is pending
//   grant_owner    winner (only meaningful when grant_valid)
// FAIR=1 alternates on a tie (the side that did not win last goes next);
// FAIR=0 always favours the data port on a tie.
module arb2_rr
    import mem_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant_owner
);

    // Grant decision
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (i_req && d_req) begin
            if (FAIR) begin
                grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
            end else begin
                grant_owner = OWN_D;
            end
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory (async read, sync write) between the
// instruction-fetch and data requesters. The winning request is latched and
// held on the memory for WAIT_CYCLES cycles, stores get a single write pulse
// in the final access cycle, read data is captured into the owner's rdata
// register, and the owner receives a one-cycle ack.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_req/i_addr/i_ack/i_rdata fetch requester (req held until ack)
//   d_req/d_we/d_addr/d_wdata  data requester (load/store)
//   d_ack/d_rdata              data completion and loaded word
//   mem_a/mem_d/mem_we/mem_spo memory interface
//   busy                       high whenever the FSM is not idle
// All outputs are registered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter bit          FAIR        = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo,

    output logic              busy
);

    // Counter preload: the access lasts cnt+1 cycles
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    owner_e              owner_q,   owner_d;
    owner_e              last_q,    last_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                we_q,      we_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ack_q,   i_ack_d;
    logic                d_ack_q,   d_ack_d;
    logic [ADDR_W-1:0]   mem_a_q,   mem_a_d;
    logic [DATA_W-1:0]   mem_d_q,   mem_d_d;
    logic                mem_we_q,  mem_we_d;
    logic                busy_q,    busy_d;

    logic                grant_valid;
    owner_e              grant_owner;

    // Tie-break between the two requesters
    arb2_rr #(
        .FAIR(FAIR)
    ) u_arb (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    if (grant_owner == OWN_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // mem_a has been stable for the whole access; sample the read
                    if (!we_q) begin
                        if (owner_q == OWN_I) begin
                            i_rdata_d = mem_spo;
                        end else begin
                            d_rdata_d = mem_spo;
                        end
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from next-state so they register alongside it
        mem_a_d  = (state_d == ST_ACCESS) ? addr_d  : '0;
        mem_d_d  = (state_d == ST_ACCESS) ? wdata_d : '0;
        mem_we_d = (state_d == ST_ACCESS) && (cnt_d == '0) && we_d;
        busy_d   = (state_d != ST_IDLE);
        i_ack_d  = (state_d == ST_RESP) && (owner_d == OWN_I);
        d_ack_d  = (state_d == ST_RESP) && (owner_d == OWN_D);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_I;
            last_q    <= OWN_D;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign mem_a   = mem_a_q;
    assign mem_d   = mem_d_q;
    assign mem_we  = mem_we_q;
    assign busy    = busy_q;

    // Configuration and protocol checks (ignored by synthesis)
    a_wait_cfg: assert property (@(posedge clk) disable iff (!rst_n)
        (WAIT_CYCLES >= 1) && (WAIT_CYCLES <= 15))
        else $error("mem_port_arbiter: WAIT_CYCLES out of range 1..15");

    a_ack_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_ack_q && d_ack_q))
        else $error("mem_port_arbiter: simultaneous i_ack and d_ack");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: four arbiter instances share the requester stimulus, each
// with its own behavioural memory.
//   g_dut[0]: WAIT_CYCLES=1, FAIR=1   g_dut[1]: WAIT_CYCLES=1, FAIR=0
//   g_dut[2]: WAIT_CYCLES=3, FAIR=1   g_dut[3]: WAIT_CYCLES=4, FAIR=1
module tb_mem_port_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we  = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;

    logic          i_ack_v   [N];
    logic          d_ack_v   [N];
    logic [DW-1:0] i_rdata_v [N];
    logic [DW-1:0] d_rdata_v [N];
    logic [AW-1:0] mem_a_v   [N];
    logic [DW-1:0] mem_d_v   [N];
    logic          mem_we_v  [N];
    logic [DW-1:0] spo_v     [N];
    logic          busy_v    [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [DW-1:0] mem [32];

        always @(posedge clk) begin
            if (pre_we) mem[pre_a] <= pre_d;
            else if (mem_we_v[g]) mem[mem_a_v[g]] <= mem_d_v[g];
        end
        assign spo_v[g] = mem[mem_a_v[g]];

        mem_port_arbiter #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .WAIT_CYCLES ((g == 2) ? 32'd3 : ((g == 3) ? 32'd4 : 32'd1)),
            .FAIR        ((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_req   (i_req),
            .i_addr  (i_addr),
            .i_ack   (i_ack_v[g]),
            .i_rdata (i_rdata_v[g]),
            .d_req   (d_req),
            .d_we    (d_we),
            .d_addr  (d_addr),
            .d_wdata (d_wdata),
            .d_ack   (d_ack_v[g]),
            .d_rdata (d_rdata_v[g]),
            .mem_a   (mem_a_v[g]),
            .mem_d   (mem_d_v[g]),
            .mem_we  (mem_we_v[g]),
            .mem_spo (spo_v[g]),
            .busy    (busy_v[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 5'd7;
        d_addr = 5'd9;
        d_we   = 1'b0;
        repeat (3) step();
        for (int g = 0; g < int'(N); g++) begin
            total++;
            if ({busy_v[g], i_ack_v[g], d_ack_v[g], mem_we_v[g]} !== 4'b0 ||
                mem_a_v[g] !== '0 || mem_d_v[g] !== '0 ||
                i_rdata_v[g] !== '0 || d_rdata_v[g] !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: busy=%b i_ack=%b d_ack=%b we=%b a=%h d=%h ir=%h dr=%h, want all 0",
                         g, busy_v[g], i_ack_v[g], d_ack_v[g], mem_we_v[g], mem_a_v[g],
                         mem_d_v[g], i_rdata_v[g], d_rdata_v[g]);
            end
        end
        rst_n = 1'b1;
        step();
        total++;
        if (busy_v[0] !== 1'b1 || mem_a_v[0] !== 5'd7) begin
            bad++;
            $display("FAIL reset_first_grant_fair: busy=%b mem_a=%0d, want 1 7", busy_v[0], mem_a_v[0]);
        end
        total++;
        if (busy_v[1] !== 1'b1 || mem_a_v[1] !== 5'd9) begin
            bad++;
            $display("FAIL reset_first_grant_fixed: busy=%b mem_a=%0d, want 1 9", busy_v[1], mem_a_v[1]);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        do_reset();
    endtask

    task automatic test_fetch();
        preload(5'd3, 32'h1234_5678);
        i_addr = 5'd3;
        i_req  = 1'b1;
        step();
        total++;
        if (mem_a_v[0] !== 5'd3 || i_ack_v[0] !== 1'b0 || d_ack_v[0] !== 1'b0 || mem_we_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL fetch_access: mem_a=%0d i_ack=%b d_ack=%b we=%b, want 3 0 0 0",
                     mem_a_v[0], i_ack_v[0], d_ack_v[0], mem_we_v[0]);
        end
        step();
        total++;
        if (i_ack_v[0] !== 1'b1 || i_rdata_v[0] !== 32'h1234_5678 || d_ack_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL fetch_ack: i_ack=%b i_rdata=%h d_ack=%b, want 1 12345678 0",
                     i_ack_v[0], i_rdata_v[0], d_ack_v[0]);
        end
        i_req = 1'b0;
        step();
        total++;
        if (i_ack_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || i_rdata_v[0] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL fetch_after: i_ack=%b busy=%b i_rdata=%h, want 0 0 12345678",
                     i_ack_v[0], busy_v[0], i_rdata_v[0]);
        end
        do_reset();
    endtask

    task automatic test_store_load();
        int  wcnt;
        int  cyc;
        bit  got;
        d_we    = 1'b1;
        d_addr  = 5'd20;
        d_wdata = 32'hDEAD_BEEF;
        d_req   = 1'b1;
        wcnt = 0; cyc = 0; got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            cyc++;
            if (mem_we_v[0] === 1'b1) wcnt++;
            if (d_ack_v[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        d_req = 1'b0;
        total++;
        if (got !== 1'b1 || cyc != 2) begin
            bad++;
            $display("FAIL store_ack: seen=%b cycles=%0d, want 1 2", got, cyc);
        end
        total++;
        if (wcnt != 1) begin
            bad++;
            $display("FAIL store_we_pulses: count=%0d, want 1", wcnt);
        end
        total++;
        if (d_rdata_v[0] !== 32'h0 || g_dut[0].mem[20] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store_result: d_rdata=%h mem[20]=%h, want 00000000 deadbeef",
                     d_rdata_v[0], g_dut[0].mem[20]);
        end
        step();
        d_we    = 1'b0;
        d_wdata = 32'h0;
        d_req   = 1'b1;
        wcnt = 0; got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (mem_we_v[0] === 1'b1) wcnt++;
            if (d_ack_v[0] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        d_req = 1'b0;
        total++;
        if (got !== 1'b1 || wcnt != 0 || d_rdata_v[0] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_back: seen=%b we_pulses=%0d d_rdata=%h, want 1 0 deadbeef",
                     got, wcnt, d_rdata_v[0]);
        end
        do_reset();
    endtask

    task automatic test_contention();
        logic [7:0] seq0, seq1;
        int         n0, n1, n1_i, both;
        seq0 = '0; seq1 = '0; n0 = 0; n1 = 0; n1_i = 0; both = 0;
        i_addr = 5'd1;
        d_addr = 5'd2;
        d_we   = 1'b0;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                if (i_ack_v[g] === 1'b1 && d_ack_v[g] === 1'b1) both++;
            end
            if (n0 < 8 && i_ack_v[0] === 1'b1) begin seq0[n0] = 1'b0; n0++; end
            if (n0 < 8 && d_ack_v[0] === 1'b1) begin seq0[n0] = 1'b1; n0++; end
            if (i_ack_v[1] === 1'b1) n1_i++;
            if (n1 < 8 && d_ack_v[1] === 1'b1) begin seq1[n1] = 1'b1; n1++; end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        total++;
        if (n0 != 4 || seq0[3:0] !== 4'b1010) begin
            bad++;
            $display("FAIL contention_fair: acks=%0d order(lsb first,1=D)=%b, want 4 1010", n0, seq0[3:0]);
        end
        total++;
        if (n1 != 4 || seq1[3:0] !== 4'b1111 || n1_i != 0) begin
            bad++;
            $display("FAIL contention_fixed: d_acks=%0d i_acks=%0d, want 4 0", n1, n1_i);
        end
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL ack_exclusive: overlap cycles=%0d, want 0", both);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_store();
        bit seen_we, seen_ack, stray_busy;
        seen_we = 1'b0; seen_ack = 1'b0; stray_busy = 1'b0;
        preload(5'd31, 32'hA5A5_A5A5);
        d_we    = 1'b1;
        d_addr  = 5'd31;
        d_wdata = 32'h1111_2222;
        d_req   = 1'b1;
        step();
        total++;
        if (busy_v[2] !== 1'b1 || mem_a_v[2] !== 5'd31 || mem_we_v[2] !== 1'b0 ||
            mem_d_v[2] !== 32'h1111_2222) begin
            bad++;
            $display("FAIL midrst_access1: busy=%b mem_a=%0d we=%b mem_d=%h, want 1 31 0 11112222",
                     busy_v[2], mem_a_v[2], mem_we_v[2], mem_d_v[2]);
        end
        step();
        if (mem_we_v[2] === 1'b1) seen_we = 1'b1;
        if (d_ack_v[2] === 1'b1) seen_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy_v[2] !== 1'b0 || mem_a_v[2] !== '0 || mem_we_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async: busy=%b mem_a=%0d we=%b, want 0 0 0",
                     busy_v[2], mem_a_v[2], mem_we_v[2]);
        end
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (2) begin
            step();
            if (mem_we_v[2] === 1'b1) seen_we = 1'b1;
            if (d_ack_v[2] === 1'b1) seen_ack = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            step();
            if (mem_we_v[2] === 1'b1) seen_we = 1'b1;
            if (d_ack_v[2] === 1'b1) seen_ack = 1'b1;
            if (busy_v[2] !== 1'b0) stray_busy = 1'b1;
        end
        total++;
        if (seen_we || seen_ack) begin
            bad++;
            $display("FAIL midrst_no_effect: we_seen=%b ack_seen=%b, want 0 0", seen_we, seen_ack);
        end
        total++;
        if (g_dut[2].mem[31] !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL midrst_mem31: got %h, want a5a5a5a5", g_dut[2].mem[31]);
        end
        total++;
        if (stray_busy) begin
            bad++;
            $display("FAIL midrst_idle: busy seen after release, want idle");
        end
        do_reset();
    endtask

    task automatic test_latency();
        preload(5'd0, 32'h0BAD_F00D);
        preload(5'd17, 32'h7777_7777);
        d_we   = 1'b0;
        d_addr = 5'd0;
        d_req  = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (mem_a_v[3] !== 5'd0 || busy_v[3] !== 1'b1 || d_ack_v[3] !== 1'b0) begin
                bad++;
                $display("FAIL latency_hold[%0d]: mem_a=%0d busy=%b d_ack=%b, want 0 1 0",
                         k, mem_a_v[3], busy_v[3], d_ack_v[3]);
            end
            if (k == 1) d_addr = 5'd17;
            step();
        end
        total++;
        if (d_ack_v[3] !== 1'b1 || d_rdata_v[3] !== 32'h0BAD_F00D || i_ack_v[3] !== 1'b0) begin
            bad++;
            $display("FAIL latency_ack: d_ack=%b d_rdata=%h i_ack=%b, want 1 0badf00d 0",
                     d_ack_v[3], d_rdata_v[3], i_ack_v[3]);
        end
        d_req = 1'b0;
        step();
        total++;
        if (d_ack_v[3] !== 1'b0 || busy_v[3] !== 1'b0 || d_rdata_v[3] !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL latency_after: d_ack=%b busy=%b d_rdata=%h, want 0 0 0badf00d",
                     d_ack_v[3], busy_v[3], d_rdata_v[3]);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_contention();
        test_reset_mid_store();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
